// File: rtl/bram_rd_ctrl.sv
// Read-side companion to the BRAM writer: queues written addresses, reads each word back
// and streams {addr,data} out. Optional compare logic is enabled by defining BRAM_RD_CMP_EN.
module bram_rd_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_bit,
  input  logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          q_ovf
`ifdef BRAM_RD_CMP_EN
  ,
  input  logic [DW-1:0] exp_data,
  output logic          mis_pulse,
  output logic [15:0]   mis_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] Q_FULL = (PW+1)'(QDEPTH);
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   q_mem_r [QDEPTH];
  logic [PW-1:0]   wp_r;
  logic [PW-1:0]   rp_r;
  logic [PW:0]     cnt_r;
  logic            wr_bit_r;
  logic [2:0]      lat_cnt_r;

  logic            push_s;
  logic            pop_s;
  logic            q_empty_s;
  logic            q_full_s;
  logic            accept_s;
  logic            drop_s;

  assign push_s    = wr_bit & ~wr_bit_r;
  assign q_empty_s = (cnt_r == {(PW+1){1'b0}});
  assign q_full_s  = (cnt_r == Q_FULL);
  assign pop_s     = (state_r == S_IDLE) & ~q_empty_s;
  // A full queue still takes the push when the head leaves in the same cycle.
  assign accept_s  = push_s & (~q_full_s | pop_s);
  assign drop_s    = push_s & q_full_s & ~pop_s;

  // Queue storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      q_mem_r[wp_r] <= wr_addr;
    end
  end

  // Strobe edge detect, queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bit_r <= 1'b0;
      wp_r     <= {PW{1'b0}};
      rp_r     <= {PW{1'b0}};
      cnt_r    <= {(PW+1){1'b0}};
      q_ovf    <= 1'b0;
    end else begin
      wr_bit_r <= wr_bit;
      if (accept_s) begin
        wp_r <= wp_r + PW'(1);
      end
      if (pop_s) begin
        rp_r <= rp_r + PW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (drop_s) begin
        q_ovf <= 1'b1;
      end
    end
  end

  // Read sequencer: pop, issue, wait out the BRAM latency, present until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= {AW{1'b0}};
      lat_cnt_r <= 3'd0;
      out_valid <= 1'b0;
      out_addr  <= {AW{1'b0}};
      out_data  <= {DW{1'b0}};
`ifdef BRAM_RD_CMP_EN
      mis_pulse <= 1'b0;
      mis_cnt   <= 16'd0;
`endif
    end else begin
`ifdef BRAM_RD_CMP_EN
      mis_pulse <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          rd_en <= 1'b0;
          if (pop_s) begin
            rd_addr <= q_mem_r[rp_r];
            rd_en   <= 1'b1;
            state_r <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_en     <= 1'b0;
          lat_cnt_r <= LAT_INIT;
          state_r   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt_r <= lat_cnt_r - 3'd1;
          // Counter reaching zero this cycle is the cycle rd_data is valid.
          if (lat_cnt_r == 3'd1) begin
            out_data  <= rd_data;
            out_addr  <= rd_addr;
            out_valid <= 1'b1;
            state_r   <= S_PRESENT;
`ifdef BRAM_RD_CMP_EN
            if (rd_data != exp_data) begin
              mis_pulse <= 1'b1;
              if (mis_cnt != 16'hFFFF) begin
                mis_cnt <= mis_cnt + 16'd1;
              end
            end
`endif
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// Bench for bram_rd_ctrl: cycle table, directed corner sequences and a randomized
// writer/consumer run checked against an in-order expected stream and a BRAM model.
module tb_bram_rd_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int QDEPTH = 4;

  logic          r_fakeclock;
  logic          rst;
  logic          wr_bit;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          q_ovf;
`ifdef BRAM_RD_CMP_EN
  logic [DW-1:0] exp_data;
  logic          mis_pulse;
  logic [15:0]   mis_cnt;
`endif

  bram_rd_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .QDEPTH(QDEPTH)) dut (
    .clk(r_fakeclock), .rst(rst), .wr_bit(wr_bit), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .q_ovf(q_ovf)
`ifdef BRAM_RD_CMP_EN
    , .exp_data(exp_data), .mis_pulse(mis_pulse), .mis_cnt(mis_cnt)
`endif
  );

  initial r_fakeclock = 1'b0;
  always #5 r_fakeclock = ~r_fakeclock;

  // BRAM model: word for the rd_en address appears RD_LAT cycles later.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge r_fakeclock) begin
    for (int i = RD_LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= rd_en ? mem[rd_addr] : 32'hBAD0_BAD0;
  end
  assign rd_data = pipe[RD_LAT-1];

  // Output monitor: records accepted words and protocol-rule violations.
  logic [AW-1:0] got_addr [4096];
  logic [DW-1:0] got_data [4096];
  int got_n = 0, cyc = 0, last_rd = 0, rden_cnt = 0, valid_cnt = 0, mis_seen = 0;
  int hold_viol = 0, space_viol = 0, lat_viol = 0;
  bit have_rd = 0, prev_hold = 0, prev_valid = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  always @(negedge r_fakeclock) begin
    cyc++;
    if (rst) begin
      have_rd = 0; prev_hold = 0; prev_valid = 0;
    end else begin
      if (rd_en) begin
        rden_cnt++;
        if (have_rd && (cyc - last_rd) < RD_LAT + 3) space_viol++;
        last_rd = cyc; have_rd = 1;
      end
      if (out_valid && !prev_valid && (!have_rd || (cyc - last_rd) != RD_LAT + 1)) lat_viol++;
      if (prev_hold && (!out_valid || out_addr != prev_addr || out_data != prev_data)) hold_viol++;
      if (out_valid && out_ready) begin
        got_addr[got_n] = out_addr; got_data[got_n] = out_data; got_n++;
      end
      if (out_valid) valid_cnt++;
`ifdef BRAM_RD_CMP_EN
      if (mis_pulse) mis_seen++;
`endif
      prev_hold = out_valid && !out_ready;
      prev_addr = out_addr; prev_data = out_data; prev_valid = out_valid;
    end
  end

  int checks = 0, errors = 0;
  logic [AW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge r_fakeclock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [AW-1:0] a, input int hi, input int lo);
    wr_addr = a; wr_bit = 1'b1;
    tick(hi);
    wr_bit = 1'b0;
    if (lo > 0) tick(lo);
  endtask

  task automatic drain(input int base, input int want);
    for (int c = 0; c < 600 && (got_n - base) < want; c++) tick(1);
    tick(12);
  endtask

  task automatic check_stream(input string name, input int base);
    check({name, "_count"}, 64'(got_n - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_n - base; i++) begin
      check({name, "_addr"}, 64'(got_addr[base+i]), 64'(exp_q[i]));
      check({name, "_data"}, 64'(got_data[base+i]), 64'(mem[exp_q[i]]));
    end
  endtask

  typedef struct {
    logic wb; logic [7:0] wa; logic rdy;
    logic e_rd_en; logic [7:0] e_rd_addr; logic e_ov; logic [7:0] e_oa; logic e_dv;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int base, strobes, pl, gl;
    tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b1};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1; wr_bit = 1'b0; wr_addr = 8'h00; out_ready = 1'b1;
`ifdef BRAM_RD_CMP_EN
    exp_data = 32'h0;
`endif
    tick(1);
    do_reset();

    // Reset state
    @(negedge r_fakeclock);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_q_ovf", 64'(q_ovf), 64'd0);
    tick(1);

    // Single two-cycle strobe, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      wr_bit = tbl[i].wb; wr_addr = tbl[i].wa; out_ready = tbl[i].rdy;
      @(negedge r_fakeclock);
      check($sformatf("t1_rd_en[%0d]", i), 64'(rd_en), 64'(tbl[i].e_rd_en));
      check($sformatf("t1_rd_addr[%0d]", i), 64'(rd_addr), 64'(tbl[i].e_rd_addr));
      check($sformatf("t1_out_valid[%0d]", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("t1_out_addr[%0d]", i), 64'(out_addr), 64'(tbl[i].e_oa));
      check($sformatf("t1_out_data[%0d]", i), 64'(out_data),
            tbl[i].e_dv ? 64'(mem[tbl[i].e_oa]) : 64'd0);
      tick(1);
    end

    // Periodic writer, addresses 1..10
    do_reset(); base = got_n; exp_q.delete(); out_ready = 1'b1;
    for (int p = 1; p <= 10; p++) begin
      strobe(8'(p), 2, 13); exp_q.push_back(8'(p));
    end
    drain(base, 10);
    check_stream("t2", base);
    check("t2_q_ovf", 64'(q_ovf), 64'd0);

    // Stalled consumer: queue fills, sixth strobe dropped
    do_reset(); base = got_n; exp_q.delete(); out_ready = 1'b0;
    for (int a = 10; a <= 15; a++) strobe(8'(a), 2, 8);
    check("t3_q_ovf_set", 64'(q_ovf), 64'd1);
    check("t3_none_yet", 64'(got_n - base), 64'd0);
    for (int a = 10; a <= 14; a++) exp_q.push_back(8'(a));
    out_ready = 1'b1;
    drain(base, 5);
    check_stream("t3", base);
    check("t3_q_ovf_sticky", 64'(q_ovf), 64'd1);

    // Full queue: pop and new push in the same cycle
    do_reset(); base = got_n; exp_q.delete(); out_ready = 1'b0;
    for (int a = 15; a <= 19; a++) begin
      strobe(8'(a), 2, 6); exp_q.push_back(8'(a));
    end
    check("t4_q_ovf_pre", 64'(q_ovf), 64'd0);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0; wr_addr = 8'd20; wr_bit = 1'b1;
    tick(1);
    wr_bit = 1'b0;
    tick(1);
    exp_q.push_back(8'd20);
    check("t4_q_ovf", 64'(q_ovf), 64'd0);
    out_ready = 1'b1;
    drain(base, 6);
    check_stream("t4", base);

    // Reset while a read is in flight
    do_reset(); out_ready = 1'b1;
    strobe(8'h05, 1, 0);
    tick(1);
    check("t5_rd_en_issue", 64'(rd_en), 64'd1);
    check("t5_rd_addr_issue", 64'(rd_addr), 64'h05);
    tick(1);
    rst = 1'b1;
    #1;
    check("t5_rst_rd_en", 64'(rd_en), 64'd0);
    check("t5_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_out_addr", 64'(out_addr), 64'd0);
    check("t5_rst_out_data", 64'(out_data), 64'd0);
    tick(2);
    rst = 1'b0;
    base = rden_cnt; pl = valid_cnt;
    tick(30);
    check("t5_no_rd_en", 64'(rden_cnt - base), 64'd0);
    check("t5_no_valid", 64'(valid_cnt - pl), 64'd0);

    // Strobe already high when reset releases counts once
    wr_addr = 8'h33; wr_bit = 1'b1;
    do_reset(); base = got_n; exp_q.delete(); exp_q.push_back(8'h33);
    tick(3);
    wr_bit = 1'b0;
    drain(base, 1);
    check_stream("t7", base);

`ifdef BRAM_RD_CMP_EN
    do_reset(); out_ready = 1'b1;
    mem[3] = 32'hDEAD_BEEE; exp_data = 32'hDEAD_BEEF; base = mis_seen;
    strobe(8'h03, 1, 20);
    check("t6_mis_pulses", 64'(mis_seen - base), 64'd1);
    check("t6_mis_cnt", 64'(mis_cnt), 64'd1);
    exp_data = mem[4];
    strobe(8'h04, 1, 20);
    check("t6_match_cnt", 64'(mis_cnt), 64'd1);
`endif

    // Randomized writer and consumer, never more than QDEPTH outstanding
    do_reset(); base = got_n; exp_q.delete();
    strobes = 0; pl = 0; gl = 0;
    for (int c = 0; c < 30000 && strobes < 200; c++) begin
      if (pl > 0) begin
        wr_bit = 1'b1; pl--;
      end else if (gl > 0) begin
        wr_bit = 1'b0; gl--;
      end else if ((strobes - (got_n - base)) < QDEPTH) begin
        wr_addr = 8'($urandom_range(0, 255)); wr_bit = 1'b1;
        exp_q.push_back(wr_addr); strobes++;
        pl = $urandom_range(0, 2); gl = 1 + $urandom_range(0, 4);
      end else begin
        wr_bit = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    wr_bit = 1'b0; out_ready = 1'b1;
    check("rnd_strobes", 64'(strobes), 64'd200);
    drain(base, 200);
    check_stream("rnd", base);
    check("rnd_q_ovf", 64'(q_ovf), 64'd0);

    check("hold_stable", 64'(hold_viol), 64'd0);
    check("rd_spacing", 64'(space_viol), 64'd0);
    check("rd_latency", 64'(lat_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
